// File: rtl/mem_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_pkg
// Description : Shared types and helpers for the memory BIST initiator.
//               - bist_state_t : controller state encoding
//               - bist_pat     : address-derived data pattern (optionally
//                                inverted for the second pass)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_t;

  // Computed at 32 bits; callers size-cast the result down to their width,
  // which keeps the inversion correct for any width up to 32.
  function automatic logic [31:0] bist_pat(input logic [31:0] addr,
                                           input logic [31:0] seed,
                                           input logic        inv);
    logic [31:0] p;
    p = addr ^ seed;
    return inv ? ~p : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : bist_addr_ctr
// Description : W-bit address counter with synchronous clear, count enable
//               and terminal-count flag. Wraps naturally from all-ones to 0.
// Ports       : clk   - clock
//               rst   - asynchronous active-high reset
//               clr_i - clear to zero (priority over en_i)
//               en_i  - increment enable
//               q_o   - counter value
//               tc_o  - high while the counter holds all ones
// Revision    : 1.0 - initial release
// ============================================================================
module bist_addr_ctr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q_o  = cnt_q;
  assign tc_o = (cnt_q == '1);

endmodule
`default_nettype wire

// File: rtl/mem_bist.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist
// Description : Built-in self-test initiator for the register-file memory.
//               Writes pat(a) = a ^ SEED to every location, reads each one
//               back through the memory's registered read port and reports
//               pass/fail, first failing address and a saturating error count.
//               Build option MEM_BIST_INVERT_PASS_EN adds a second pass using
//               the inverted pattern; results accumulate across both passes.
// Ports       : clk          - clock
//               rst          - asynchronous active-high reset
//               start_i      - begin a test (honoured in IDLE/DONE only)
//               busy_o       - test in progress (WR/RD/DRAIN)
//               done_o       - test finished, held until next start/reset
//               pass_o       - valid while done_o; 1 = no miscompares
//               fail_addr_o  - first miscomparing address (0 if none)
//               err_count_o  - miscompare count, saturates at 2**N
//               mem_we_o     - memory write enable
//               mem_addr_o   - memory address
//               mem_write_o  - memory write data
//               mem_read_i   - memory read data (valid one cycle after addr)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int          N    = 5,
  parameter int unsigned SEED = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic [N-1:0] fail_addr_o,
  output logic [N:0]   err_count_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_write_o,
  input  logic [N-1:0] mem_read_i
);

  localparam logic [N:0] C_ERR_MAX = {1'b1, {N{1'b0}}};

  bist_state_t  state_q, state_d;

  logic         w_start_acc;
  logic         w_ctr_en;
  logic         w_ctr_clr;
  logic [N-1:0] w_a;
  logic         w_a_tc;
  logic         w_inv;
  logic [N-1:0] w_wr_pat;
  logic [N-1:0] w_exp_pat;
  logic         w_miss;

  logic [N-1:0] addr_dly_q;
  logic         cv_q;
  logic [N:0]   err_count_q, err_count_d;
  logic [N-1:0] fail_addr_q, fail_addr_d;
  logic         first_fail_q, first_fail_d;
  logic         pass_q, pass_d;

  // --------------------------------------------------------------------------
  // Address counter
  // --------------------------------------------------------------------------
  assign w_start_acc = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign w_ctr_clr   = w_start_acc;
  assign w_ctr_en    = (state_q == WR) || (state_q == RD);

  bist_addr_ctr #(
    .W (N)
  ) u_addr_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_ctr_clr),
    .en_i  (w_ctr_en),
    .q_o   (w_a),
    .tc_o  (w_a_tc)
  );

  // --------------------------------------------------------------------------
  // Pass selection: the pass bit changes only on the DRAIN->WR edge, so the
  // final compare of the first pass (in DRAIN) still sees the plain pattern.
  // --------------------------------------------------------------------------
`ifdef MEM_BIST_INVERT_PASS_EN
  logic pass_bit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_bit_q <= 1'b0;
    end else if (w_start_acc) begin
      pass_bit_q <= 1'b0;
    end else if (state_q == DRAIN) begin
      pass_bit_q <= 1'b1;
    end
  end

  assign w_inv = pass_bit_q;
`else
  assign w_inv = 1'b0;
`endif

  assign w_wr_pat  = N'(bist_pat(32'(w_a), 32'(SEED), w_inv));
  assign w_exp_pat = N'(bist_pat(32'(addr_dly_q), 32'(SEED), w_inv));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_start_acc) state_d = WR;
      WR:      if (w_a_tc)      state_d = RD;
      RD:      if (w_a_tc)      state_d = DRAIN;
`ifdef MEM_BIST_INVERT_PASS_EN
      DRAIN:   state_d = pass_bit_q ? DONE : WR;
`else
      DRAIN:   state_d = DONE;
`endif
      DONE:    if (w_start_acc) state_d = WR;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (state and counter flops only; no path from start/read data)
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_write_o = '0;
    case (state_q)
      WR: begin
        busy_o      = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_a;
        mem_write_o = w_wr_pat;
      end
      RD: begin
        busy_o     = 1'b1;
        mem_addr_o = w_a;
      end
      DRAIN:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Compare pipeline: the address issued in an RD cycle is compared against
  // the read data returned in the following cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_dly_q <= '0;
      cv_q       <= 1'b0;
    end else begin
      if (state_q == RD) begin
        addr_dly_q <= w_a;
      end
      cv_q <= (state_q == RD);
    end
  end

  assign w_miss = cv_q && (mem_read_i != w_exp_pat);

  // --------------------------------------------------------------------------
  // Error accounting
  // --------------------------------------------------------------------------
  always_comb begin
    err_count_d  = err_count_q;
    fail_addr_d  = fail_addr_q;
    first_fail_d = first_fail_q;
    if (w_start_acc) begin
      err_count_d  = '0;
      fail_addr_d  = '0;
      first_fail_d = 1'b0;
    end else if (w_miss) begin
      if (err_count_q != C_ERR_MAX) begin
        err_count_d = err_count_q + (N+1)'(1);
      end
      if (!first_fail_q) begin
        fail_addr_d  = addr_dly_q;
        first_fail_d = 1'b1;
      end
    end
  end

  // pass is captured from the next-state count so the compare made in the
  // final DRAIN cycle is included.
  always_comb begin
    pass_d = pass_q;
    if (w_start_acc) begin
      pass_d = 1'b0;
    end else if ((state_q == DRAIN) && (state_d == DONE)) begin
      pass_d = (err_count_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q  <= '0;
      fail_addr_q  <= '0;
      first_fail_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      fail_addr_q  <= fail_addr_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  assign err_count_o = err_count_q;
  assign fail_addr_o = fail_addr_q;
  assign pass_o      = pass_q;

endmodule
`default_nettype wire
